command_uart_tx: RTL and testbench

COMMAND_UART_TX -- requirements
Module: command_uart_tx

---
 rtl/command_uart_tx.sv | 169 ++++++++++++++++
 tb/tb_command_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/command_uart_tx.sv
// Purpose : turns changes on a debounced command byte into 8N1 UART frames (LSB first, idle high).
// Ports   : uart_clk/rst_n (async active-low); data_operate command byte in; uart_tx serial out;
//           busy (frame on line), sent (stop bit done pulse), drop (pending command overwritten pulse).
// Timing  : change at edge N -> start bit from edge N+1; frame = 10*CLKS_PER_BIT cycles; sent is high
//           for the single idle cycle that follows the stop bit; all outputs come straight from flops.
module command_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  IGNORE_CODE  = 8'h00
) (
    input  logic       uart_clk,
    input  logic       rst_n,
    input  logic [7:0] data_operate,
    output logic       uart_tx,
    output logic       busy,
    output logic       sent,
    output logic       drop
);

    // Bit-cycle counter only ever counts 0..CLKS_PER_BIT-1, so ceil(log2) bits suffice.
    localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_idx_n;
    logic [7:0]    shift;
    logic [7:0]    shift_n;
    logic          tx_n;
    logic          sent_n;

    logic [7:0]    last_in;
    logic [7:0]    pending;
    logic          pending_valid;

    logic          change;
    logic          consume;
    logic          bit_done;

    // ------------------------------------------------------------------
    // Command capture: one-entry pending slot, latest command wins.
    // ------------------------------------------------------------------
    assign change  = (data_operate != last_in) && (data_operate != IGNORE_CODE);
    // The FSM takes the pending byte on the same edge it leaves IDLE.
    assign consume = (state == IDLE) && pending_valid;

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            // Resetting last_in to the ignore code makes a value already present
            // at release look like a fresh command on the first edge.
            last_in       <= IGNORE_CODE;
            pending       <= '0;
            pending_valid <= 1'b0;
            drop          <= 1'b0;
        end else begin
            last_in <= data_operate;
            drop    <= 1'b0;
            if (change) begin
                pending       <= data_operate;
                pending_valid <= 1'b1;
                // Only an unconsumed pending byte is lost; if the FSM takes it
                // this very edge the new byte simply queues behind it.
                drop          <= pending_valid && !consume;
            end else if (consume) begin
                pending_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    assign bit_done = (cnt == CNT_LAST);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        sent_n    = 1'b0;
        tx_n      = 1'b1;

        case (state)
            IDLE: begin
                if (pending_valid) begin
                    // Shift register is loaded only here, so commands arriving
                    // mid-frame can never disturb the byte on the line.
                    state_n   = START;
                    shift_n   = pending;
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    sent_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Line level is derived from the next state so the registered output
        // changes on the same edge as the state it belongs to.
        case (state_n)
            IDLE:    tx_n = 1'b1;
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[bit_idx_n];
            STOP:    tx_n = 1'b1;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= '0;
            uart_tx <= 1'b1;
            busy    <= 1'b0;
            sent    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            uart_tx <= tx_n;
            busy    <= (state_n != IDLE);
            sent    <= sent_n;
        end
    end

endmodule

// File: tb/tb_command_uart_tx.sv
// Purpose : scoreboard bench for command_uart_tx; one instance at 4 clocks/bit, one at 2 clocks/bit.
// Ports   : none; drives both instances and decodes their serial lines in monitor processes.
// Checks  : expected bytes are queued at stimulus time and popped when a decoded frame completes.
module tb_command_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] d4 = 8'h00;
    logic [7:0] d2 = 8'h00;
    logic       tx4, busy4, sent4, drop4;
    logic       tx2, busy2, sent2, drop2;

    logic [1:0] tx_w, busy_w, sent_w;
    assign tx_w   = {tx2, tx4};
    assign busy_w = {busy2, busy4};
    assign sent_w = {sent2, sent4};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_end [2];
    int last_gap [2];
    int sent_cnt4 = 0, sent_cnt2 = 0, drop_cnt4 = 0, drop_cnt2 = 0;

    logic [7:0] q4 [$];
    logic [7:0] q2 [$];

    command_uart_tx #(.CLKS_PER_BIT(4), .IGNORE_CODE(8'h00)) dut4 (
        .uart_clk(clk), .rst_n(rst_n), .data_operate(d4),
        .uart_tx(tx4), .busy(busy4), .sent(sent4), .drop(drop4)
    );

    command_uart_tx #(.CLKS_PER_BIT(2), .IGNORE_CODE(8'h00)) dut2 (
        .uart_clk(clk), .rst_n(rst_n), .data_operate(d2),
        .uart_tx(tx2), .busy(busy2), .sent(sent2), .drop(drop2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (sent4) sent_cnt4 <= sent_cnt4 + 1;
            if (sent2) sent_cnt2 <= sent_cnt2 + 1;
            if (drop4) drop_cnt4 <= drop_cnt4 + 1;
            if (drop2) drop_cnt2 <= drop_cnt2 + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int qsize(input int which);
        return (which == 0) ? q4.size() : q2.size();
    endfunction

    // Decodes frames on one instance's line; a reset inside a frame abandons it.
    task automatic monitor(input int which, input int cpb);
        logic [7:0] got;
        logic [7:0] exp;
        logic       ok;
        logic       ab;
        int         pos;
        forever begin
            @(negedge clk);
            if (rst_n && tx_w[which] == 1'b0) begin
                last_gap[which] = cyc - last_end[which];
                ok  = 1'b1;
                ab  = 1'b0;
                got = 8'h00;
                for (int c = 0; c < 10 * cpb; c++) begin
                    if (c != 0) @(negedge clk);
                    if (!rst_n) begin
                        ab = 1'b1;
                        break;
                    end
                    if (busy_w[which] !== 1'b1 || sent_w[which] !== 1'b0) ok = 1'b0;
                    pos = c / cpb;
                    if (pos == 0) begin
                        if (tx_w[which] !== 1'b0) ok = 1'b0;
                    end else if (pos == 9) begin
                        if (tx_w[which] !== 1'b1) ok = 1'b0;
                    end else if (c % cpb == 0) begin
                        got[pos-1] = tx_w[which];
                    end else if (tx_w[which] !== got[pos-1]) begin
                        ok = 1'b0;
                    end
                end
                if (!ab) begin
                    @(negedge clk);
                    check($sformatf("frame_shape%0d", which), {31'd0, ok}, 32'd1);
                    check($sformatf("sent_at_end%0d", which), {31'd0, sent_w[which]}, 32'd1);
                    check($sformatf("busy_after_frame%0d", which), {31'd0, busy_w[which]}, 32'd0);
                    last_end[which] = cyc;
                    if (qsize(which) == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame%0d: got 0x%0h, expected no frame", which, got);
                    end else begin
                        exp = (which == 0) ? q4.pop_front() : q2.pop_front();
                        check($sformatf("frame_byte%0d", which), {24'd0, got}, {24'd0, exp});
                    end
                end
            end
        end
    endtask

    initial monitor(0, 4);
    initial monitor(1, 2);

    task automatic wait_drain(input int which, input int budget);
        int n = 0;
        while (n < budget && (qsize(which) != 0 || busy_w[which] == 1'b1)) begin
            step(1);
            n++;
        end
        if (n >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout%0d: %0d frames still queued after %0d cycles", which, qsize(which), n);
        end
        step(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        last_end[0] = -1000;
        last_end[1] = -1000;
        last_gap[0] = 0;
        last_gap[1] = 0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset_tx", {31'd0, tx4}, 32'd1);
        check("reset_busy", {31'd0, busy4}, 32'd0);
        check("reset_sent", {31'd0, sent4}, 32'd0);
        check("reset_drop", {31'd0, drop4}, 32'd0);
        check("reset_tx2", {31'd0, tx2}, 32'd1);
        step(3);
        rst_n = 1'b1;
        step(3);
        check("idle_tx", {31'd0, tx4}, 32'd1);

        // 0xA5 frame and start-bit latency
        d4 = 8'hA5;
        q4.push_back(8'hA5);
        step(1);
        check("latency_edge_n_tx", {31'd0, tx4}, 32'd1);
        check("latency_edge_n_busy", {31'd0, busy4}, 32'd0);
        step(1);
        check("latency_start_tx", {31'd0, tx4}, 32'd0);
        check("latency_start_busy", {31'd0, busy4}, 32'd1);
        wait_drain(0, 200);

        // 0x01, ignore code, 0x01 again: two identical frames
        d4 = 8'h01;
        q4.push_back(8'h01);
        step(50);
        d4 = 8'h00;
        step(50);
        d4 = 8'h01;
        q4.push_back(8'h01);
        step(50);
        wait_drain(0, 200);

        // Overwrite while pending: 0x02 is replaced by 0x03 mid-frame
        d4 = 8'h00;
        step(2);
        d4 = 8'h01;
        q4.push_back(8'h01);
        step(1);
        step(10);
        d4 = 8'h02;
        step(1);
        check("no_drop_first_pending", {31'd0, drop4}, 32'd0);
        step(3);
        d4 = 8'h03;
        q4.push_back(8'h03);
        step(1);
        check("drop_on_overwrite", {31'd0, drop4}, 32'd1);
        step(1);
        check("drop_one_cycle", {31'd0, drop4}, 32'd0);
        wait_drain(0, 300);
        check("back_to_back_gap", last_gap[0], 32'd1);

        // Reset during DATA bit 3 aborts the frame; 0x04 present at release is sent
        d4 = 8'h00;
        step(2);
        d4 = 8'h10;
        q4.push_back(8'h10);
        step(1);
        step(17);
        #2 rst_n = 1'b0;
        #1;
        check("abort_tx", {31'd0, tx4}, 32'd1);
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_sent", {31'd0, sent4}, 32'd0);
        q4.delete();
        d4 = 8'h04;
        step(3);
        rst_n = 1'b1;
        q4.push_back(8'h04);
        wait_drain(0, 200);

        // Minimum bit width: 2 clocks/bit, back-to-back frames
        d2 = 8'h5A;
        q2.push_back(8'h5A);
        step(4);
        d2 = 8'h3C;
        q2.push_back(8'h3C);
        wait_drain(1, 200);
        check("cpb2_back_to_back_gap", last_gap[1], 32'd1);

        step(5);
        check("sent_pulses4", sent_cnt4, 32'd6);
        check("drop_pulses4", drop_cnt4, 32'd1);
        check("sent_pulses2", sent_cnt2, 32'd2);
        check("drop_pulses2", drop_cnt2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
